tcm_sram_ctrl: RTL
==================

// Module: tcm_sram_ctrl
// PURPOSE
//  Bus-side controller sitting directly upstream of the TCM SRAM (ITCM/DTCM instance).
//  Accepts byte-addressed valid/ready commands and drives the SRAM word-address, data, write-enable and mask pins.
//  Returns one response per command with read data or an error flag.
//  At most one transaction is outstanding, and the 2-cycle access pipeline is fixed.
// PARAMETERS
//  DP    512  SRAM depth in words; a word index >= DP is out of range
//  DW    32   data width; must equal MW*8
//  MW    4    byte-mask width
//  AW    32   address width, for both the bus address and the SRAM address
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   reset, asynchronous, active-low
//  cmd_valid  in   1   command valid
//  cmd_ready  out  1   command accept; a transfer occurs when cmd_valid & cmd_ready
//  cmd_addr   in   AW  byte address; bits [1:0] are ignored
//  cmd_read   in   1   1=read, 0=write
//  cmd_wdata  in   DW  write data
//  cmd_wmask  in   MW  byte write mask; bit i enables byte i
//  rsp_valid  out  1   response valid
//  rsp_ready  in   1   response accept
//  rsp_rdata  out  DW  read data; 0 for writes and for errors
//  rsp_err    out  1   address out of range
//  ram_addr   out  AW  word index to the SRAM, zero-extended
//  ram_din    out  DW  SRAM write data
//  ram_we     out  1   SRAM write enable; SRAM treats ~we as a read
//  ram_wem    out  MW  SRAM byte mask
//  ram_dout   in   DW  SRAM read data; valid in the ACCESS cycle for the held ram_addr
// BEHAVIOUR
//  Reset (async): state=IDLE.
//    Outputs cleared to 0: rsp_valid, rsp_err, rsp_rdata, ram_addr, ram_din, ram_we, ram_wem.
//    Reset takes effect immediately, mid-transaction included.
//    An ACCESS-cycle write is suppressed because ram_we falls with the state.
//    A pending response is dropped; no response is issued for a command aborted by reset.
//  States:
//    IDLE   -> ACCESS on accept with in-range address;
//              -> RESP on accept with out-of-range address.
//    ACCESS -> RESP unconditionally, 1 cycle.
//    RESP   -> IDLE when rsp_ready and no new accept;
//              -> ACCESS or RESP if a new command is accepted in the same cycle.
//  cmd_ready = (state==IDLE) | (state==RESP & rsp_ready), which gives back-to-back throughput of 1 cmd / 2 clk.
//  On accept, register the following:
//    addr_q = cmd_addr[AW-1:2]
//    rd_q, wdata_q, wmask_q
//    err_q = (cmd_addr[AW-1:2] >= DP)
//  ACCESS:
//    ram_addr = addr_q.
//    ram_we = ~rd_q; ram_wem = rd_q ? 0 : wmask_q; ram_din = wdata_q.
//    Write commits at the ACCESS->RESP edge.
//    rsp_rdata is captured from ram_dout at the end of ACCESS if rd_q, else set to 0.
//  Outside ACCESS: ram_we=0 and ram_wem=0.
//    ram_addr and ram_din hold their last values, so the SRAM read path stays stable.
//  Latency, counted from the accept edge N:
//    in-range command: rsp_valid rises at N+2;
//    out-of-range command: rsp_valid rises at N+1 with rsp_err=1 and rsp_rdata=0, and the SRAM is untouched.
//  A write with wmask=0 still passes through ACCESS with ram_we=1 and ram_wem=0, and gets a normal response.
//  While rsp_valid & ~rsp_ready: rsp_valid, rsp_rdata and rsp_err are held stable, and cmd_ready=0.
//  cmd_* may change freely when not accepted; the controller only uses registered copies after the accept.
//  Address boundary: index DP-1 is legal; index DP and any address wrap-around are errors, never aliased.
// TESTING
//  1. Reset, then idle: all outputs 0, cmd_ready=1 -> release rst_n -> still 0 / 1.
//  2. Write 0x100, data 0xDEADBEEF, mask 4'hF; then read 0x100, rsp_ready=1 ->
//     write: ram_we=1 for 1 cycle at ram_addr=0x40, rsp at N+2 with rdata=0;
//     read: rsp_rdata=0xDEADBEEF at N+2, err=0.
//  3. Write mask 4'b0010, data 0x0000AA00 to a word holding 0x11223344, then read it ->
//     rsp_rdata=0x1122AA44.
//  4. Read 0x7FC (index 511): err=0. Read 0x800 (index 512):
//     rsp at N+1, err=1, rdata=0, ram_we never asserted.
//  5. Hold rsp_ready=0 for 5 cycles after a read ->
//     rsp_valid/rsp_rdata are stable and cmd_ready=0.
//     Raise rsp_ready with the next cmd_valid=1 -> that command is accepted in the same cycle.
//  6. Drop rst_n during the ACCESS cycle of a write ->
//     ram_we falls immediately, the word is unchanged on re-read, and no response is issued.

Source files
------------

// File: rtl/tcm_sram_ctrl.sv
// tcm_sram_ctrl: valid/ready command front-end for a TCM SRAM with a fixed 2-cycle access pipeline.
// One transaction outstanding; out-of-range word indices answer with an error and never touch the SRAM.
module tcm_sram_ctrl #(
   parameter int DP = 512,
   parameter int DW = 32,
   parameter int MW = 4,
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_addr,
   input  logic          cmd_read,
   input  logic [DW-1:0] cmd_wdata,
   input  logic [MW-1:0] cmd_wmask,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   output logic [MW-1:0] ram_wem,
   input  logic [DW-1:0] ram_dout
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [AW-3:0] DP_W = (AW-2)'(DP);

   state_t          state_q, state_d;
   logic [AW-3:0]   addr_q;
   logic            rd_q;
   logic [DW-1:0]   wdata_q;
   logic [MW-1:0]   wmask_q;
   logic [DW-1:0]   rdata_q;
   logic            err_q;
   logic            accept;
   logic            in_range;

   assign cmd_ready = (state_q == IDLE) | ((state_q == RESP) & rsp_ready);
   assign accept    = cmd_valid & cmd_ready;
   assign in_range  = cmd_addr[AW-1:2] < DP_W;

   always_comb begin
      state_d = state_q;
      if (state_q == ACCESS)
         state_d = RESP;
      else if (accept)
         state_d = in_range ? ACCESS : RESP;
      else if ((state_q == RESP) & rsp_ready)
         state_d = IDLE;
   end

   // SRAM-side address/data only load for in-range commands so the read path stays stable otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept & in_range) begin
            addr_q  <= cmd_addr[AW-1:2];
            rd_q    <= cmd_read;
            wdata_q <= cmd_wdata;
            wmask_q <= cmd_wmask;
         end
         if (accept) begin
            err_q   <= ~in_range;
            rdata_q <= '0;
         end else if (state_q == ACCESS) begin
            rdata_q <= rd_q ? ram_dout : '0;
         end else if ((state_q == RESP) & rsp_ready) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
         end
      end
   end

   assign rsp_valid = state_q == RESP;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign ram_addr  = {2'b00, addr_q};
   assign ram_din   = wdata_q;
   assign ram_we    = (state_q == ACCESS) & ~rd_q;
   assign ram_wem   = ram_we ? wmask_q : '0;

endmodule
